crc64_rx_chk: RTL and testbench

//  Receive-side CRC64 checker for 64-bit word frames: sop on first payload word, eop on the trailing CRC word.
//  - Recomputes CRC64 over the payload (poly x^64+x^4+x^3+x+1) and compares it with the trailing CRC word.
//  - Forwards payload with one-word hold-back, so the CRC word is stripped and eop moves to the last payload word.
//  - Sits between the link deframer and the frame consumer, clk_sys domain.

---
 rtl/crc64_pkg.sv | 35 +++
 rtl/crc64_d64_comb.sv | 20 ++
 rtl/crc64_rx_chk.sv | 210 +++++++++++++++++++++
 tb/tb_crc64_rx_chk.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/crc64_pkg.sv
// -----------------------------------------------------------------------------
// crc64_pkg
// Shared CRC64 definitions for the receive checker and the transmitter.
//   - CRC64_POLY / CRC64_INIT : x^64+x^4+x^3+x+1, all-ones seed
//   - crc64_d64_next()        : one 64-bit data word folded into the CRC
//   - state_t                 : checker FSM encodings
// CRC is MSB-first, no reflection, no final XOR.
// -----------------------------------------------------------------------------
package crc64_pkg;

    localparam int unsigned DATA_W = 64;
    localparam int unsigned STAT_W = 16;

    localparam logic [DATA_W-1:0] CRC64_POLY = 64'h0000_0000_0000_001B;
    localparam logic [DATA_W-1:0] CRC64_INIT = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RECV = 1'b1
    } state_t;

    // The step is linear in (crc ^ din): shift the combined word out MSB-first.
    function automatic logic [DATA_W-1:0] crc64_d64_next(
        input logic [DATA_W-1:0] crc,
        input logic [DATA_W-1:0] din
    );
        logic [DATA_W-1:0] m;
        m = crc ^ din;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            m = {m[DATA_W-2:0], 1'b0} ^ (m[DATA_W-1] ? CRC64_POLY : '0);
        end
        return m;
    endfunction

endpackage : crc64_pkg

// File: rtl/crc64_d64_comb.sv
// -----------------------------------------------------------------------------
// crc64_d64_comb
// Purely combinational CRC64 step over one 64-bit word.
//   i_crc   [63:0]  current CRC value
//   i_din   [63:0]  data word to fold in
//   o_crc_c [63:0]  next CRC value (combinational)
// -----------------------------------------------------------------------------
module crc64_d64_comb
    import crc64_pkg::*;
(
    input  logic [DATA_W-1:0] i_crc,
    input  logic [DATA_W-1:0] i_din,
    output logic [DATA_W-1:0] o_crc_c
);

    always_comb begin
        o_crc_c = crc64_d64_next(i_crc, i_din);
    end

endmodule : crc64_d64_comb

// File: rtl/crc64_rx_chk.sv
// -----------------------------------------------------------------------------
// crc64_rx_chk
// Receive-side CRC64 checker for 64-bit word frames. The payload is forwarded
// with a one-word hold-back so the trailing CRC word is stripped and eop lands
// on the last payload word; the CRC word is compared with the recomputed CRC.
//
// Ports
//   clk_sys, rst_sys       clock, asynchronous active-low reset
//   rx_din/vld/sop/eop     input words; eop marks the trailing CRC word
//   out_data/vld/eop       forwarded payload, one-cycle pulse per word
//   chk_done               one-cycle pulse when a frame check finishes
//   chk_err, len_err       CRC mismatch / length-framing fault, with chk_done
//   frm_len [LEN_W-1:0]    payload word count, saturates at MAX_WORDS+1
//   stat_clr, stat_frm_cnt, stat_err_cnt
//                          only when CRC64_RX_STAT_EN is defined
//
// Optional feature macro: CRC64_RX_STAT_EN (frame / error statistics counters).
// -----------------------------------------------------------------------------
module crc64_rx_chk
    import crc64_pkg::*;
#(
    parameter int unsigned MAX_WORDS = 256,
    parameter int unsigned LEN_W     = 9
) (
    input  logic              clk_sys,
    input  logic              rst_sys,
    input  logic [DATA_W-1:0] rx_din,
    input  logic              rx_vld,
    input  logic              rx_sop,
    input  logic              rx_eop,
    output logic [DATA_W-1:0] out_data,
    output logic              out_vld,
    output logic              out_eop,
    output logic              chk_done,
    output logic              chk_err,
    output logic              len_err,
    output logic [LEN_W-1:0]  frm_len
`ifdef CRC64_RX_STAT_EN
    ,
    input  logic              stat_clr,
    output logic [STAT_W-1:0] stat_frm_cnt,
    output logic [STAT_W-1:0] stat_err_cnt
`endif
);

    localparam logic [LEN_W-1:0] CNT_MAX = LEN_W'(MAX_WORDS);
    localparam logic [LEN_W-1:0] CNT_SAT = LEN_W'(MAX_WORDS + 1);

    state_t             r_state,    w_state_nxt;
    logic [DATA_W-1:0]  r_crc,      w_crc_nxt;
    logic [DATA_W-1:0]  r_hold,     w_hold_nxt;
    logic [LEN_W-1:0]   r_cnt,      w_cnt_nxt;
    logic [DATA_W-1:0]  r_out_data, w_out_data_nxt;
    logic               r_out_vld,  w_out_vld_nxt;
    logic               r_out_eop,  w_out_eop_nxt;
    logic               r_chk_done, w_chk_done_nxt;
    logic               r_chk_err,  w_chk_err_nxt;
    logic               r_len_err,  w_len_err_nxt;
    logic [LEN_W-1:0]   r_frm_len,  w_frm_len_nxt;

    logic [DATA_W-1:0]  w_crc_base;
    logic [DATA_W-1:0]  w_crc_step;
    logic [LEN_W-1:0]   w_cnt_inc;

    // A new frame (sop, or any word seen from IDLE) always folds from the seed.
    assign w_crc_base = ((r_state == ST_IDLE) || rx_sop) ? CRC64_INIT : r_crc;
    assign w_cnt_inc  = (r_cnt >= CNT_SAT) ? r_cnt : (r_cnt + LEN_W'(1));

    crc64_d64_comb u_crc_step (
        .i_crc   (w_crc_base),
        .i_din   (rx_din),
        .o_crc_c (w_crc_step)
    );

    // Next-state and output decode.
    always_comb begin
        w_state_nxt    = r_state;
        w_crc_nxt      = r_crc;
        w_hold_nxt     = r_hold;
        w_cnt_nxt      = r_cnt;
        w_out_data_nxt = r_out_data;
        w_out_vld_nxt  = 1'b0;
        w_out_eop_nxt  = 1'b0;
        w_chk_done_nxt = 1'b0;
        w_chk_err_nxt  = r_chk_err;
        w_len_err_nxt  = r_len_err;
        w_frm_len_nxt  = r_frm_len;

        if (rx_vld) begin
            case (r_state)
                ST_IDLE: begin
                    if (rx_sop && !rx_eop) begin
                        w_state_nxt = ST_RECV;
                        w_crc_nxt   = w_crc_step;
                        w_hold_nxt  = rx_din;
                        w_cnt_nxt   = LEN_W'(1);
                    end else if (rx_eop) begin
                        // Zero-payload frame or orphan eop: framing fault.
                        w_chk_done_nxt = 1'b1;
                        w_chk_err_nxt  = 1'b0;
                        w_len_err_nxt  = 1'b1;
                        w_frm_len_nxt  = '0;
                    end
                end

                ST_RECV: begin
                    if (rx_sop) begin
                        // Restart: abort the open frame, the held word is dropped.
                        w_chk_done_nxt = 1'b1;
                        w_chk_err_nxt  = 1'b0;
                        w_len_err_nxt  = 1'b1;
                        if (rx_eop) begin
                            w_frm_len_nxt = '0;
                            w_state_nxt   = ST_IDLE;
                        end else begin
                            w_frm_len_nxt = r_cnt;
                            w_crc_nxt     = w_crc_step;
                            w_hold_nxt    = rx_din;
                            w_cnt_nxt     = LEN_W'(1);
                        end
                    end else if (rx_eop) begin
                        // rx_din is the CRC word: compare, release the last payload word.
                        w_out_data_nxt = r_hold;
                        w_out_vld_nxt  = 1'b1;
                        w_out_eop_nxt  = 1'b1;
                        w_chk_done_nxt = 1'b1;
                        w_chk_err_nxt  = (rx_din != r_crc);
                        w_len_err_nxt  = (r_cnt > CNT_MAX);
                        w_frm_len_nxt  = r_cnt;
                        w_state_nxt    = ST_IDLE;
                    end else begin
                        w_out_data_nxt = r_hold;
                        w_out_vld_nxt  = 1'b1;
                        w_crc_nxt      = w_crc_step;
                        w_hold_nxt     = rx_din;
                        w_cnt_nxt      = w_cnt_inc;
                    end
                end

                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk_sys or negedge rst_sys) begin
        if (!rst_sys) begin
            r_state    <= ST_IDLE;
            r_crc      <= CRC64_INIT;
            r_hold     <= '0;
            r_cnt      <= '0;
            r_out_data <= '0;
            r_out_vld  <= 1'b0;
            r_out_eop  <= 1'b0;
            r_chk_done <= 1'b0;
            r_chk_err  <= 1'b0;
            r_len_err  <= 1'b0;
            r_frm_len  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_crc      <= w_crc_nxt;
            r_hold     <= w_hold_nxt;
            r_cnt      <= w_cnt_nxt;
            r_out_data <= w_out_data_nxt;
            r_out_vld  <= w_out_vld_nxt;
            r_out_eop  <= w_out_eop_nxt;
            r_chk_done <= w_chk_done_nxt;
            r_chk_err  <= w_chk_err_nxt;
            r_len_err  <= w_len_err_nxt;
            r_frm_len  <= w_frm_len_nxt;
        end
    end

    assign out_data = r_out_data;
    assign out_vld  = r_out_vld;
    assign out_eop  = r_out_eop;
    assign chk_done = r_chk_done;
    assign chk_err  = r_chk_err;
    assign len_err  = r_len_err;
    assign frm_len  = r_frm_len;

`ifdef CRC64_RX_STAT_EN
    logic [STAT_W-1:0] r_stat_frm_cnt;
    logic [STAT_W-1:0] r_stat_err_cnt;

    // Saturating statistics; counted on the same edge chk_done is registered.
    always_ff @(posedge clk_sys or negedge rst_sys) begin
        if (!rst_sys) begin
            r_stat_frm_cnt <= '0;
            r_stat_err_cnt <= '0;
        end else if (stat_clr) begin
            r_stat_frm_cnt <= '0;
            r_stat_err_cnt <= '0;
        end else if (w_chk_done_nxt) begin
            if (r_stat_frm_cnt != '1) begin
                r_stat_frm_cnt <= r_stat_frm_cnt + STAT_W'(1);
            end
            if ((w_chk_err_nxt || w_len_err_nxt) && (r_stat_err_cnt != '1)) begin
                r_stat_err_cnt <= r_stat_err_cnt + STAT_W'(1);
            end
        end
    end

    assign stat_frm_cnt = r_stat_frm_cnt;
    assign stat_err_cnt = r_stat_err_cnt;
`endif

endmodule : crc64_rx_chk

// File: tb/tb_crc64_rx_chk.sv
// -----------------------------------------------------------------------------
// tb_crc64_rx_chk
// Directed bench for crc64_rx_chk (default build, statistics disabled).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_crc64_rx_chk;

    localparam int unsigned MAX_WORDS = 256;
    localparam int unsigned LEN_W     = 9;

    logic              clk_sys = 1'b0;
    logic              rst_sys = 1'b0;
    logic [63:0]       rx_din  = '0;
    logic              rx_vld  = 1'b0;
    logic              rx_sop  = 1'b0;
    logic              rx_eop  = 1'b0;
    logic [63:0]       out_data;
    logic              out_vld;
    logic              out_eop;
    logic              chk_done;
    logic              chk_err;
    logic              len_err;
    logic [LEN_W-1:0]  frm_len;

    int n_checks = 0;
    int n_fail   = 0;

    logic [64:0]      cap_q[$];
    logic [64:0]      exp_q[$];
    logic [63:0]      pl_q[$];
    logic             res_err_q[$];
    logic             res_len_q[$];
    logic             res_eop_q[$];
    logic [LEN_W-1:0] res_flen_q[$];

    always #5 clk_sys = ~clk_sys;

    crc64_rx_chk #(
        .MAX_WORDS (MAX_WORDS),
        .LEN_W     (LEN_W)
    ) dut (
        .clk_sys  (clk_sys),
        .rst_sys  (rst_sys),
        .rx_din   (rx_din),
        .rx_vld   (rx_vld),
        .rx_sop   (rx_sop),
        .rx_eop   (rx_eop),
        .out_data (out_data),
        .out_vld  (out_vld),
        .out_eop  (out_eop),
        .chk_done (chk_done),
        .chk_err  (chk_err),
        .len_err  (len_err),
        .frm_len  (frm_len)
    );

    // Output monitor.
    always @(negedge clk_sys) begin
        if (out_vld) cap_q.push_back({out_eop, out_data});
        if (chk_done) begin
            res_err_q.push_back(chk_err);
            res_len_q.push_back(len_err);
            res_eop_q.push_back(out_eop);
            res_flen_q.push_back(frm_len);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Bit-serial reference CRC, MSB of the data word first.
    function automatic logic [63:0] ref_crc(input logic [63:0] c, input logic [63:0] d);
        logic fb;
        for (int i = 63; i >= 0; i--) begin
            fb = c[63] ^ d[i];
            c  = {c[62:0], 1'b0};
            if (fb) c = c ^ 64'h1B;
        end
        return c;
    endfunction

    task automatic drive(input logic [63:0] d, input logic s, input logic e, input int unsigned gap);
        repeat (gap) begin
            @(negedge clk_sys);
            rx_vld = 1'b0; rx_sop = 1'b0; rx_eop = 1'b0;
        end
        @(negedge clk_sys);
        rx_din = d; rx_vld = 1'b1; rx_sop = s; rx_eop = e;
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) begin
            @(negedge clk_sys);
            rx_vld = 1'b0; rx_sop = 1'b0; rx_eop = 1'b0;
        end
    endtask

    task automatic clear_q();
        cap_q.delete(); exp_q.delete();
        res_err_q.delete(); res_len_q.delete(); res_eop_q.delete(); res_flen_q.delete();
    endtask

    // Sends pl_q as one frame with a model CRC word (optionally corrupted).
    task automatic send_frame(input logic [63:0] flip, input int unsigned maxgap);
        logic [63:0] c;
        c = 64'hFFFF_FFFF_FFFF_FFFF;
        foreach (pl_q[i]) begin
            drive(pl_q[i], (i == 0), 1'b0, $urandom_range(0, maxgap));
            c = ref_crc(c, pl_q[i]);
            exp_q.push_back({(i == pl_q.size() - 1), pl_q[i]});
        end
        drive(c ^ flip, 1'b0, 1'b1, $urandom_range(0, maxgap));
        idle(3);
    endtask

    task automatic check_words(input string tag);
        check({tag, " nwords"}, 64'(cap_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            check($sformatf("%s w%0d data", tag, i), cap_q[i][63:0], exp_q[i][63:0]);
            check($sformatf("%s w%0d eop", tag, i), 64'(cap_q[i][64]), 64'(exp_q[i][64]));
        end
    endtask

    task automatic check_res(input string tag, input int idx, input int nres,
                             input logic err, input logic len, input logic eop,
                             input logic chk_len, input logic [LEN_W-1:0] flen);
        check({tag, " ndone"}, 64'(res_err_q.size()), 64'(nres));
        if (res_err_q.size() > idx) begin
            check({tag, " chk_err"}, 64'(res_err_q[idx]), 64'(err));
            check({tag, " len_err"}, 64'(res_len_q[idx]), 64'(len));
            check({tag, " eop@done"}, 64'(res_eop_q[idx]), 64'(eop));
            if (chk_len) check({tag, " frm_len"}, 64'(res_flen_q[idx]), 64'(flen));
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, " out_data"}, out_data, 64'h0);
        check({tag, " out_vld"},  64'(out_vld), 64'h0);
        check({tag, " out_eop"},  64'(out_eop), 64'h0);
        check({tag, " chk_done"}, 64'(chk_done), 64'h0);
        check({tag, " chk_err"},  64'(chk_err), 64'h0);
        check({tag, " len_err"},  64'(len_err), 64'h0);
        check({tag, " frm_len"},  64'(frm_len), 64'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state.
        repeat (3) @(negedge clk_sys);
        check_outputs_zero("reset");
        rst_sys = 1'b1;
        idle(2);

        // Zero-data frame: hand-computed CRC of one all-zero word is 0xCA.
        clear_q();
        exp_q.push_back({1'b1, 64'h0});
        drive(64'h0, 1'b1, 1'b0, 0);
        drive(64'h0000_0000_0000_00CA, 1'b0, 1'b1, 0);
        idle(3);
        check_words("zero");
        check_res("zero", 0, 1, 1'b0, 1'b0, 1'b1, 1'b1, LEN_W'(1));

        // Same frame with CRC bit 0 flipped.
        clear_q();
        exp_q.push_back({1'b1, 64'h0});
        drive(64'h0, 1'b1, 1'b0, 1);
        drive(64'h0000_0000_0000_00CB, 1'b0, 1'b1, 0);
        idle(3);
        check_words("badcrc");
        check_res("badcrc", 0, 1, 1'b1, 1'b0, 1'b1, 1'b1, LEN_W'(1));

        // 8-word random payload with random rx_vld gaps.
        clear_q();
        pl_q.delete();
        for (int i = 0; i < 8; i++) pl_q.push_back({$urandom, $urandom});
        send_frame(64'h0, 3);
        check_words("rand8");
        check_res("rand8", 0, 1, 1'b0, 1'b0, 1'b1, 1'b1, LEN_W'(8));

        // Restart: frame A aborted after 3 words, frame B of 4 words checks clean.
        clear_q();
        drive(64'hA000_0000_0000_0000, 1'b1, 1'b0, 0);
        drive(64'hA000_0000_0000_0001, 1'b0, 1'b0, 0);
        drive(64'hA000_0000_0000_0002, 1'b0, 1'b0, 1);
        exp_q.push_back({1'b0, 64'hA000_0000_0000_0000});
        exp_q.push_back({1'b0, 64'hA000_0000_0000_0001});
        pl_q.delete();
        for (int i = 0; i < 4; i++) pl_q.push_back(64'hB000_0000_0000_0000 | 64'(i));
        send_frame(64'h0, 1);
        check_words("restart");
        check_res("restartA", 0, 2, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        check_res("restartB", 1, 2, 1'b0, 1'b0, 1'b1, 1'b1, LEN_W'(4));

        // Overlong frame: MAX_WORDS+2 words, count saturates at MAX_WORDS+1.
        clear_q();
        pl_q.delete();
        for (int i = 0; i < MAX_WORDS + 2; i++) pl_q.push_back(64'h0123_4567_89AB_CDEF * 64'(i + 1));
        send_frame(64'h0, 0);
        check_words("long");
        check_res("long", 0, 1, 1'b0, 1'b1, 1'b1, 1'b1, LEN_W'(MAX_WORDS + 1));

        // Orphan words in IDLE: plain word is discarded, eop raises a framing fault.
        clear_q();
        drive(64'h1111, 1'b0, 1'b0, 0);
        drive(64'h2222, 1'b0, 1'b1, 0);
        idle(3);
        check_words("orphan");
        check_res("orphan", 0, 1, 1'b0, 1'b1, 1'b0, 1'b1, '0);

        // Zero payload: sop and eop on the same word.
        clear_q();
        drive(64'h3333, 1'b1, 1'b1, 0);
        idle(3);
        check_words("zeropl");
        check_res("zeropl", 0, 1, 1'b0, 1'b1, 1'b0, 1'b1, '0);

        // Reset mid-frame, then a clean frame.
        clear_q();
        drive(64'h4444, 1'b1, 1'b0, 0);
        drive(64'h5555, 1'b0, 1'b0, 0);
        drive(64'h6666, 1'b0, 1'b0, 0);
        @(negedge clk_sys);
        rx_vld = 1'b0; rx_sop = 1'b0; rx_eop = 1'b0;
        rst_sys = 1'b0;
        #1;
        check_outputs_zero("midrst");
        idle(2);
        rst_sys = 1'b1;
        idle(3);
        check("midrst ndone", 64'(res_err_q.size()), 64'h0);
        clear_q();
        exp_q.push_back({1'b1, 64'h0});
        drive(64'h0, 1'b1, 1'b0, 0);
        drive(64'h0000_0000_0000_00CA, 1'b0, 1'b1, 0);
        idle(3);
        check_words("postrst");
        check_res("postrst", 0, 1, 1'b0, 1'b0, 1'b1, 1'b1, LEN_W'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_crc64_rx_chk
